// File: rtl/mem_bus_pkg.sv
// Shared definitions for the instruction/data memory bus arbiter:
// FSM state encoding, memory access size encodings and the default width.
package mem_bus_pkg;

  localparam int DEFAULT_BIT_WIDTH = 32;

  // Access size encodings carried on d_size / m_size (1x means byte)
  localparam logic [1:0] SIZE_WORD = 2'b00;
  localparam logic [1:0] SIZE_HALF = 2'b01;
  localparam logic [1:0] SIZE_BYTE = 2'b10;

  // Arbiter FSM state enumeration
  typedef logic [1:0] state_t;
  localparam state_t S_IDLE   = 2'd0;
  localparam state_t S_I_BUSY = 2'd1;
  localparam state_t S_D_BUSY = 2'd2;
  localparam state_t S_RESP   = 2'd3;

endpackage

// File: rtl/arb_starve_cnt.sv
// Saturating count of data grants made while an instruction fetch waits.
// Used only when the arbiter is built with ARB_STARVE_GUARD_EN.
module arb_starve_cnt #(
  parameter int LIMIT = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic inc,
  input  logic clr,
  output logic at_limit
);

  localparam int CW = $clog2(LIMIT + 1);

  logic [CW-1:0] count;

  assign at_limit = (count == CW'(LIMIT));

  // Clear on instruction grant, otherwise count up to LIMIT and stick there
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      count <= '0;
    end else if (clr) begin
      count <= '0;
    end else if (inc && !at_limit) begin
      count <= count + 1'b1;
    end
  end

endmodule

// File: rtl/mem_bus_arbiter.sv
// Two-requester (instruction fetch / data access) arbiter onto one shared
// memory port. Data normally wins; with ARB_STARVE_GUARD_EN defined a
// saturating counter forces an instruction grant after STARVE_LIMIT data
// grants made while a fetch was waiting.
//
// Handshake: a requester raises *_req and holds it (and its address/data)
// until its *_ack_n pulses low for one cycle. The memory sees m_req held
// high with stable m_* until it answers with m_ack_n low for a cycle; the
// arbiter then spends one RESP cycle before accepting a new request.
module mem_bus_arbiter
  import mem_bus_pkg::*;
#(
  parameter int BIT_WIDTH    = DEFAULT_BIT_WIDTH,
  parameter int STARVE_LIMIT = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 i_req,
  input  logic [BIT_WIDTH-1:0] i_addr,
  output logic [BIT_WIDTH-1:0] i_rdata,
  output logic                 i_ack_n,
  input  logic                 d_req,
  input  logic                 d_write,
  input  logic [1:0]           d_size,
  input  logic [BIT_WIDTH-1:0] d_addr,
  input  logic [BIT_WIDTH-1:0] d_wdata,
  output logic [BIT_WIDTH-1:0] d_rdata,
  output logic                 d_ack_n,
  output logic                 m_req,
  output logic                 m_write,
  output logic [1:0]           m_size,
  output logic [BIT_WIDTH-1:0] m_addr,
  output logic [BIT_WIDTH-1:0] m_wdata,
  input  logic [BIT_WIDTH-1:0] m_rdata,
  input  logic                 m_ack_n,
  output logic [1:0]           state_dbg
);

  state_t state;
  logic   starve_hit;
  logic   grant_d;
  logic   grant_i;

  assign state_dbg = state;

`ifdef ARB_STARVE_GUARD_EN
  logic at_limit;

  arb_starve_cnt #(
    .LIMIT(STARVE_LIMIT)
  ) u_starve_cnt (
    .clk     (clk),
    .rst     (rst),
    .inc     (grant_d && i_req),
    .clr     (grant_i),
    .at_limit(at_limit)
  );

  assign starve_hit = at_limit && i_req;
`else
  // Keeps the limit parameter referenced when the guard is compiled out
  logic [31:0] unused_starve_limit;
  assign unused_starve_limit = 32'(STARVE_LIMIT);
  assign starve_hit          = 1'b0;
`endif

  // Grant selection, only meaningful in IDLE
  always_comb begin
    grant_d = (state == S_IDLE) && d_req && !starve_hit;
    grant_i = (state == S_IDLE) && i_req && !grant_d;
  end

  // FSM plus registered memory-side outputs, read data and ack pulses
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state   <= S_IDLE;
      m_req   <= 1'b0;
      m_write <= 1'b0;
      m_size  <= SIZE_WORD;
      m_addr  <= '0;
      m_wdata <= '0;
      i_rdata <= '0;
      d_rdata <= '0;
      i_ack_n <= 1'b1;
      d_ack_n <= 1'b1;
    end else begin
      i_ack_n <= 1'b1;
      d_ack_n <= 1'b1;
      case (state)
        S_IDLE: begin
          if (grant_d) begin
            state   <= S_D_BUSY;
            m_req   <= 1'b1;
            m_write <= d_write;
            m_size  <= d_size;
            m_addr  <= d_addr;
            m_wdata <= d_wdata;
          end else if (grant_i) begin
            state   <= S_I_BUSY;
            m_req   <= 1'b1;
            m_write <= 1'b0;
            m_size  <= SIZE_WORD;
            m_addr  <= i_addr;
            m_wdata <= '0;
          end
        end
        S_I_BUSY: begin
          if (!m_ack_n) begin
            state   <= S_RESP;
            m_req   <= 1'b0;
            i_rdata <= m_rdata;
            i_ack_n <= 1'b0;
          end
        end
        S_D_BUSY: begin
          if (!m_ack_n) begin
            state   <= S_RESP;
            m_req   <= 1'b0;
            d_ack_n <= 1'b0;
            // Stores return nothing; keep the last load result
            if (!m_write) d_rdata <= m_rdata;
          end
        end
        default: begin
          state <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// Directed bench for mem_bus_arbiter. Scenario tasks drive the requesters
// and act as the memory, comparing against hand-computed values.
module tb_mem_bus_arbiter;

  localparam int W = 32;
  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_D_BUSY = 2'd2;

  logic         clk = 1'b0;
  logic         rst;
  logic         i_req, d_req, d_write, m_ack_n;
  logic [1:0]   d_size;
  logic [W-1:0] i_addr, d_addr, d_wdata, m_rdata;
  logic [W-1:0] i_rdata, d_rdata, m_addr, m_wdata;
  logic         i_ack_n, d_ack_n, m_req, m_write;
  logic [1:0]   m_size, state_dbg;

  int n_vec = 0;
  int n_bad = 0;

  // ---- clock / reset ----
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL global_timeout: got still running expected finished");
    $fatal(1, "timeout");
  end

  mem_bus_arbiter #(.BIT_WIDTH(W), .STARVE_LIMIT(4)) dut (
    .clk(clk), .rst(rst),
    .i_req(i_req), .i_addr(i_addr), .i_rdata(i_rdata), .i_ack_n(i_ack_n),
    .d_req(d_req), .d_write(d_write), .d_size(d_size), .d_addr(d_addr),
    .d_wdata(d_wdata), .d_rdata(d_rdata), .d_ack_n(d_ack_n),
    .m_req(m_req), .m_write(m_write), .m_size(m_size), .m_addr(m_addr),
    .m_wdata(m_wdata), .m_rdata(m_rdata), .m_ack_n(m_ack_n),
    .state_dbg(state_dbg)
  );

  // ---- driver tasks ----
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Memory responder: waits (bounded) for m_req, records the request, holds
  // m_ack_n high for 'waits' edges while watching m_* for stability, then
  // acknowledges for one edge. Returns just after the capture edge.
  task automatic serve(input int waits, input logic [W-1:0] rdata,
                       output logic got, output logic stable,
                       output logic [W-1:0] addr, output logic wr,
                       output logic [1:0] sz, output logic [W-1:0] wd);
    got = 1'b0;
    stable = 1'b1;
    for (int k = 0; k < 20 && !got; k++) begin
      if (m_req === 1'b1) got = 1'b1;
      else step();
    end
    addr = m_addr; wr = m_write; sz = m_size; wd = m_wdata;
    if (got) begin
      for (int k = 0; k < waits; k++) begin
        step();
        if (m_req !== 1'b1 || m_addr !== addr || m_write !== wr ||
            m_size !== sz || m_wdata !== wd) stable = 1'b0;
      end
      m_rdata = rdata;
      m_ack_n = 1'b0;
      step();
      m_ack_n = 1'b1;
      m_rdata = '0;
    end
  endtask

  // ---- scenarios ----
  task automatic test_reset();
    rst = 1'b0; i_req = 0; d_req = 0; d_write = 0; d_size = 2'b00;
    i_addr = '0; d_addr = '0; d_wdata = '0; m_rdata = '0; m_ack_n = 1'b1;
    step(); step();
    n_vec++; if (m_req !== 1'b0) begin n_bad++; $display("FAIL reset_m_req: got %b expected 0", m_req); end
    n_vec++; if ({m_write, m_size} !== 3'b000) begin n_bad++; $display("FAIL reset_m_ctl: got %b expected 000", {m_write, m_size}); end
    n_vec++; if (m_addr !== 32'h0 || m_wdata !== 32'h0) begin n_bad++; $display("FAIL reset_m_data: got %h/%h expected 0/0", m_addr, m_wdata); end
    n_vec++; if (i_rdata !== 32'h0 || d_rdata !== 32'h0) begin n_bad++; $display("FAIL reset_rdata: got %h/%h expected 0/0", i_rdata, d_rdata); end
    n_vec++; if ({i_ack_n, d_ack_n} !== 2'b11) begin n_bad++; $display("FAIL reset_acks: got %b expected 11", {i_ack_n, d_ack_n}); end
    n_vec++; if (state_dbg !== ST_IDLE) begin n_bad++; $display("FAIL reset_state: got %0d expected 0", state_dbg); end
    rst = 1'b1;
    step();
    // stray memory ack in IDLE must do nothing
    m_ack_n = 1'b0; m_rdata = 32'hBAD0BAD0;
    step();
    m_ack_n = 1'b1;
    n_vec++; if (state_dbg !== ST_IDLE || m_req !== 1'b0) begin n_bad++; $display("FAIL idle_stray_ack_state: got %0d/%b expected 0/0", state_dbg, m_req); end
    n_vec++; if ({i_ack_n, d_ack_n} !== 2'b11 || i_rdata !== 32'h0 || d_rdata !== 32'h0) begin n_bad++; $display("FAIL idle_stray_ack_out: got %b %h %h expected 11 0 0", {i_ack_n, d_ack_n}, i_rdata, d_rdata); end
  endtask

  task automatic test_fetch();
    logic got, st, wr; logic [1:0] sz; logic [W-1:0] a, wd;
    i_addr = 32'h00010000; i_req = 1'b1;
    serve(0, 32'h24020001, got, st, a, wr, sz, wd);
    n_vec++; if (got !== 1'b1) begin n_bad++; $display("FAIL fetch_grant: got %b expected 1", got); end
    n_vec++; if (a !== 32'h00010000 || wr !== 1'b0 || sz !== 2'b00) begin n_bad++; $display("FAIL fetch_mreq: got %h %b %b expected 00010000 0 00", a, wr, sz); end
    n_vec++; if ({i_ack_n, d_ack_n} !== 2'b01) begin n_bad++; $display("FAIL fetch_ack: got %b expected 01", {i_ack_n, d_ack_n}); end
    n_vec++; if (i_rdata !== 32'h24020001) begin n_bad++; $display("FAIL fetch_rdata: got %h expected 24020001", i_rdata); end
    n_vec++; if (m_req !== 1'b0) begin n_bad++; $display("FAIL fetch_mreq_clear: got %b expected 0", m_req); end
    i_req = 1'b0;
    step();
    n_vec++; if ({i_ack_n, d_ack_n} !== 2'b11) begin n_bad++; $display("FAIL fetch_ack_width: got %b expected 11", {i_ack_n, d_ack_n}); end
    step();
    n_vec++; if (m_req !== 1'b0 || state_dbg !== ST_IDLE) begin n_bad++; $display("FAIL fetch_back_idle: got %b/%0d expected 0/0", m_req, state_dbg); end
  endtask

  task automatic test_half_load();
    logic got, st, wr; logic [1:0] sz; logic [W-1:0] a, wd;
    d_req = 1'b1; d_write = 1'b0; d_size = 2'b01; d_addr = 32'h00000204; d_wdata = 32'h0;
    serve(1, 32'h0000BEEF, got, st, a, wr, sz, wd);
    n_vec++; if (got !== 1'b1 || st !== 1'b1) begin n_bad++; $display("FAIL load_grant: got %b/%b expected 1/1", got, st); end
    n_vec++; if (a !== 32'h00000204 || wr !== 1'b0 || sz !== 2'b01) begin n_bad++; $display("FAIL load_mreq: got %h %b %b expected 00000204 0 01", a, wr, sz); end
    n_vec++; if ({i_ack_n, d_ack_n} !== 2'b10) begin n_bad++; $display("FAIL load_ack: got %b expected 10", {i_ack_n, d_ack_n}); end
    n_vec++; if (d_rdata !== 32'h0000BEEF || i_rdata !== 32'h24020001) begin n_bad++; $display("FAIL load_rdata: got %h/%h expected 0000beef/24020001", d_rdata, i_rdata); end
    d_req = 1'b0;
    step(); step();
  endtask

  task automatic test_word_store();
    logic got, st, wr; logic [1:0] sz; logic [W-1:0] a, wd;
    d_req = 1'b1; d_write = 1'b1; d_size = 2'b00; d_addr = 32'h00000100; d_wdata = 32'hDEADBEEF;
    serve(3, 32'h12345678, got, st, a, wr, sz, wd);
    n_vec++; if (got !== 1'b1) begin n_bad++; $display("FAIL store_grant: got %b expected 1", got); end
    n_vec++; if (st !== 1'b1) begin n_bad++; $display("FAIL store_hold_stable: got %b expected 1", st); end
    n_vec++; if (a !== 32'h00000100 || wr !== 1'b1 || sz !== 2'b00 || wd !== 32'hDEADBEEF) begin n_bad++; $display("FAIL store_mreq: got %h %b %b %h expected 00000100 1 00 deadbeef", a, wr, sz, wd); end
    n_vec++; if ({i_ack_n, d_ack_n} !== 2'b10) begin n_bad++; $display("FAIL store_ack: got %b expected 10", {i_ack_n, d_ack_n}); end
    n_vec++; if (d_rdata !== 32'h0000BEEF) begin n_bad++; $display("FAIL store_rdata_kept: got %h expected 0000beef", d_rdata); end
    d_req = 1'b0;
    step();
    n_vec++; if (d_ack_n !== 1'b1) begin n_bad++; $display("FAIL store_ack_width: got %b expected 1", d_ack_n); end
    step();
  endtask

  task automatic test_collision();
    logic got, st, wr; logic [1:0] sz; logic [W-1:0] a, wd;
    i_addr = 32'h00020000; d_addr = 32'h00000300; d_write = 1'b0; d_size = 2'b10;
    i_req = 1'b1; d_req = 1'b1;
    serve(0, 32'hA5A5A5A5, got, st, a, wr, sz, wd);
    n_vec++; if (got !== 1'b1 || a !== 32'h00000300 || sz !== 2'b10) begin n_bad++; $display("FAIL collide_first: got %b %h %b expected 1 00000300 10", got, a, sz); end
    n_vec++; if ({i_ack_n, d_ack_n} !== 2'b10 || d_rdata !== 32'hA5A5A5A5) begin n_bad++; $display("FAIL collide_first_ack: got %b %h expected 10 a5a5a5a5", {i_ack_n, d_ack_n}, d_rdata); end
    d_req = 1'b0;
    serve(2, 32'h11112222, got, st, a, wr, sz, wd);
    n_vec++; if (got !== 1'b1 || a !== 32'h00020000 || wr !== 1'b0 || sz !== 2'b00) begin n_bad++; $display("FAIL collide_second: got %b %h %b %b expected 1 00020000 0 00", got, a, wr, sz); end
    n_vec++; if ({i_ack_n, d_ack_n} !== 2'b01 || i_rdata !== 32'h11112222) begin n_bad++; $display("FAIL collide_second_ack: got %b %h expected 01 11112222", {i_ack_n, d_ack_n}, i_rdata); end
    i_req = 1'b0;
    step(); step();
  endtask

  task automatic test_starvation();
    logic got, st, wr; logic [1:0] sz; logic [W-1:0] a, wd;
    logic [W-1:0] exp_addr [6];
    // fresh counter
    rst = 1'b0; step(); rst = 1'b1; step();
`ifdef ARB_STARVE_GUARD_EN
    exp_addr = '{32'h400, 32'h400, 32'h400, 32'h400, 32'h30000, 32'h400};
`else
    exp_addr = '{32'h400, 32'h400, 32'h400, 32'h400, 32'h400, 32'h400};
`endif
    i_addr = 32'h00030000; d_addr = 32'h00000400; d_write = 1'b0; d_size = 2'b00;
    i_req = 1'b1; d_req = 1'b1;
    for (int j = 0; j < 6; j++) begin
      serve(0, 32'(j), got, st, a, wr, sz, wd);
      n_vec++; if (got !== 1'b1 || a !== exp_addr[j]) begin n_bad++; $display("FAIL starve_grant_%0d: got %b %h expected 1 %h", j, got, a, exp_addr[j]); end
      if (i_ack_n === 1'b0) i_req = 1'b0;
    end
    d_req = 1'b0;
`ifndef ARB_STARVE_GUARD_EN
    serve(0, 32'h99, got, st, a, wr, sz, wd);
    n_vec++; if (got !== 1'b1 || a !== 32'h00030000 || i_ack_n !== 1'b0) begin n_bad++; $display("FAIL starve_late_fetch: got %b %h %b expected 1 00030000 0", got, a, i_ack_n); end
    i_req = 1'b0;
`endif
    step(); step();
  endtask

  task automatic test_mid_reset();
    logic got, st, wr; logic [1:0] sz; logic [W-1:0] a, wd;
    logic ack_seen;
    d_req = 1'b1; d_write = 1'b0; d_size = 2'b00; d_addr = 32'h00000500; d_wdata = 32'hCAFEF00D;
    got = 1'b0;
    for (int k = 0; k < 20 && !got; k++) begin
      if (m_req === 1'b1) got = 1'b1;
      else step();
    end
    n_vec++; if (got !== 1'b1 || state_dbg !== ST_D_BUSY) begin n_bad++; $display("FAIL midrst_busy: got %b/%0d expected 1/2", got, state_dbg); end
    rst = 1'b0; d_req = 1'b0;
    #1;
    n_vec++; if (m_req !== 1'b0 || m_addr !== 32'h0 || m_wdata !== 32'h0 || {m_write, m_size} !== 3'b000) begin n_bad++; $display("FAIL midrst_m_out: got %b %h %h %b expected 0 0 0 000", m_req, m_addr, m_wdata, {m_write, m_size}); end
    n_vec++; if (i_rdata !== 32'h0 || d_rdata !== 32'h0 || state_dbg !== ST_IDLE) begin n_bad++; $display("FAIL midrst_state: got %h %h %0d expected 0 0 0", i_rdata, d_rdata, state_dbg); end
    m_ack_n = 1'b0; m_rdata = 32'h0000FFFF;
    step();
    rst = 1'b1;
    ack_seen = 1'b0;
    for (int k = 0; k < 3; k++) begin
      step();
      if (i_ack_n !== 1'b1 || d_ack_n !== 1'b1 || state_dbg !== ST_IDLE || d_rdata !== 32'h0) ack_seen = 1'b1;
    end
    m_ack_n = 1'b1;
    n_vec++; if (ack_seen !== 1'b0) begin n_bad++; $display("FAIL midrst_late_ack_ignored: got %b expected 0", ack_seen); end
    i_addr = 32'h00040000; i_req = 1'b1;
    serve(0, 32'h00000077, got, st, a, wr, sz, wd);
    n_vec++; if (got !== 1'b1 || a !== 32'h00040000 || i_ack_n !== 1'b0 || i_rdata !== 32'h77) begin n_bad++; $display("FAIL midrst_next_grant: got %b %h %b %h expected 1 00040000 0 77", got, a, i_ack_n, i_rdata); end
    i_req = 1'b0;
    step(); step();
  endtask

  // ---- sequence and final report ----
  initial begin
    test_reset();
    test_fetch();
    test_half_load();
    test_word_store();
    test_collision();
    test_starvation();
    test_mid_reset();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule

// File: doc/mem_bus_arbiter.md
MEM_BUS_ARBITER -- requirements
Module: mem_bus_arbiter

Interface
REQ-001 Parameter BIT_WIDTH, default 32, sets the address and data width.
REQ-002 Parameter STARVE_LIMIT, default 4, sets the maximum number of consecutive data grants while an instruction request waits.
REQ-003 Port clk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-004 Port rst, input, 1 bit: reset, asynchronous and active-low.
REQ-005 Port i_req, input, 1 bit: instruction-fetch request; held high until i_ack_n is low.
REQ-006 Port i_addr, input, BIT_WIDTH bits: fetch address; held stable while i_req is high.
REQ-007 Port i_rdata, output, BIT_WIDTH bits: fetched instruction word.
REQ-008 Port i_ack_n, output, 1 bit: active-low, one-cycle fetch completion.
REQ-009 Port d_req, input, 1 bit: data-access request; held high until d_ack_n is low.
REQ-010 Port d_write, input, 1 bit: 1 = store, 0 = load.
REQ-011 Port d_size, input, 2 bits: 00 = word, 01 = half, 1x = byte.
REQ-012 Port d_addr, input, BIT_WIDTH bits: data address.
REQ-013 Port d_wdata, input, BIT_WIDTH bits: store data.
REQ-014 Port d_rdata, output, BIT_WIDTH bits: load data.
REQ-015 Port d_ack_n, output, 1 bit: active-low, one-cycle data completion.
REQ-016 Ports m_req, m_write, m_size[1:0], m_addr, m_wdata: outputs to the shared memory, all registered.
REQ-017 Port m_rdata, input, BIT_WIDTH bits: memory read data, valid when m_ack_n is low.
REQ-018 Port m_ack_n, input, 1 bit: active-low memory completion; arrives any number of cycles (≥1) after m_req rises.

Function
REQ-019 The FSM SHALL have four states:
- IDLE
- I_BUSY
- D_BUSY
- RESP
REQ-020 In IDLE, grant selection on the next edge SHALL be:
- d_req high → D_BUSY, unless the starvation override applies;
- else i_req high → I_BUSY;
- else stay in IDLE.
REQ-021 On entering a BUSY state, the requester's address, write flag, size and wdata SHALL be latched into the m_* outputs and m_req set to 1.
- Instruction grants drive m_write=0 and m_size=00.
REQ-022 In BUSY, each edge with m_ack_n high SHALL hold all m_* outputs unchanged (no limit on wait cycles).
REQ-023 In BUSY, an edge with m_ack_n low SHALL:
- clear m_req;
- capture m_rdata into i_rdata or d_rdata (stores leave d_rdata unchanged);
- drive the granted requester's ack_n low for exactly one cycle;
- move to RESP.
REQ-024 RESP SHALL last one cycle, ignore both requests, and return to IDLE.
- Request-to-ack latency is therefore ≥2 cycles; issue spacing is ≥3 cycles per transaction.
REQ-025 i_ack_n and d_ack_n SHALL never be low in the same cycle; m_req SHALL never be high in IDLE or RESP.
REQ-026 m_ack_n low while in IDLE or RESP SHALL be ignored with no state change.
REQ-027 Simultaneous i_req and d_req in IDLE SHALL grant data, except under REQ-031.
REQ-028 i_rdata and d_rdata SHALL hold their last captured value until the next capture.

Reset
REQ-029 rst low SHALL immediately set:
- state = IDLE, starvation counter = 0;
- m_req = 0, m_write = 0, m_size = 00, m_addr = 0, m_wdata = 0;
- i_rdata = 0, d_rdata = 0;
- i_ack_n = 1, d_ack_n = 1.
REQ-030 Reset during BUSY SHALL abandon the transaction with no ack; a later m_ack_n low SHALL be ignored per REQ-026.

Configuration
REQ-031 With macro ARB_STARVE_GUARD_EN defined, the starvation guard SHALL operate as follows:
- a counter increments on each data grant made while i_req is high;
- it clears on every instruction grant;
- when it equals STARVE_LIMIT and i_req is high, the next IDLE grant goes to instruction even if d_req is high;
- it saturates at STARVE_LIMIT.
REQ-032 Without ARB_STARVE_GUARD_EN, data SHALL always win and no counter SHALL exist.

Structure
REQ-033 A shared package mem_bus_pkg SHALL hold:
- the state enumeration;
- the size encodings SIZE_WORD, SIZE_HALF, SIZE_BYTE;
- default BIT_WIDTH.
REQ-034 One sub-module, arb_starve_cnt (the saturating counter), SHALL be instantiated only under ARB_STARVE_GUARD_EN; the rest stays flat.

Verification
REQ-035 Fetch only: i_req=1, i_addr=0x00010000, m_ack_n low 1 cycle after m_req, m_rdata=0x24020001 → m_addr=0x00010000, m_write=0, i_rdata=0x24020001, i_ack_n low one cycle, d_ack_n stays 1.
REQ-036 Word store: d_req=1, d_write=1, d_size=00, d_addr=0x100, d_wdata=0xDEADBEEF, m_ack_n delayed 3 cycles → m_* held stable 3 cycles, d_ack_n low once, d_rdata unchanged.
REQ-037 Collision: i_req and d_req rise on the same edge → data served first, then instruction; the two acks fall in distinct cycles.
REQ-038 Starvation with macro, STARVE_LIMIT=4: d_req held high continuously, i_req high → 4 data grants, then 1 instruction grant, then data resumes. Without the macro, no instruction grant occurs while d_req stays high.
REQ-039 Mid-transaction reset: rst low while in D_BUSY, then m_ack_n low → all outputs at reset values, no ack pulses, next grant starts from IDLE.
